// File: rtl/mem_wb_dual_writeback.sv
// MEM/WB stage for the dual-issue datapath: registers both lanes' results and drives
// the two register-file write ports, suppressing r0 writes and same-register collisions.
module mem_wb_dual_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              btnc_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              EX_MEM_valid_i,
    input  logic              EX_MEM_RegWrite_i,
    input  logic              EX_MEM_MemtoReg_i,
    input  logic [ADDR_W-1:0] EX_MEM_write_register_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              EX_MEM_valid_r,
    input  logic              EX_MEM_RegWrite_r,
    input  logic              EX_MEM_MemtoReg_r,
    input  logic [ADDR_W-1:0] EX_MEM_write_register_r,
    input  logic [DATA_W-1:0] alu_result_r,
    input  logic [DATA_W-1:0] mem_rdata_r,
    output logic              MEM_WB_RegWrite_i,
    output logic [ADDR_W-1:0] MEM_WB_write_register_i,
    output logic [DATA_W-1:0] write_data_i,
    output logic              MEM_WB_RegWrite_r,
    output logic [ADDR_W-1:0] MEM_WB_write_register_r,
    output logic [DATA_W-1:0] write_data_r,
    output logic [31:0]       retire_count,
    output logic [CNT_W-1:0]  collision_count
);

    logic              valid_i_q, valid_r_q;
    logic              regwrite_i_q, regwrite_r_q;
    logic              written_i_q, written_r_q;
    logic              collide_q;
    logic [4:0]        dest_i_q, dest_r_q;
    logic [DATA_W-1:0] data_i_q, data_r_q;
    logic [31:0]       retire_q;
    logic [CNT_W-1:0]  coll_q;

    logic       qual_i_in, qual_r_in, collide_in;
    logic [1:0] retire_inc;

    // Only the low five destination bits name a register.
    logic unused_dest_bits;
    assign unused_dest_bits = ^{EX_MEM_write_register_i[ADDR_W-1:5],
                                EX_MEM_write_register_r[ADDR_W-1:5]};

    assign qual_i_in  = EX_MEM_valid_i & EX_MEM_RegWrite_i & (EX_MEM_write_register_i[4:0] != 5'd0);
    assign qual_r_in  = EX_MEM_valid_r & EX_MEM_RegWrite_r & (EX_MEM_write_register_r[4:0] != 5'd0);
    assign collide_in = qual_i_in & qual_r_in &
                        (EX_MEM_write_register_i[4:0] == EX_MEM_write_register_r[4:0]);
    assign retire_inc = {1'b0, EX_MEM_valid_i} + {1'b0, EX_MEM_valid_r};

    // Priority: reset, flush, stall, capture. A stall marks the held entry as already written.
    always_ff @(posedge clk or posedge btnc_i) begin
        if (btnc_i) begin
            valid_i_q    <= 1'b0;
            valid_r_q    <= 1'b0;
            regwrite_i_q <= 1'b0;
            regwrite_r_q <= 1'b0;
            written_i_q  <= 1'b0;
            written_r_q  <= 1'b0;
            collide_q    <= 1'b0;
            dest_i_q     <= '0;
            dest_r_q     <= '0;
            data_i_q     <= '0;
            data_r_q     <= '0;
            retire_q     <= '0;
            coll_q       <= '0;
        end else if (flush_i) begin
            valid_i_q <= 1'b0;
            valid_r_q <= 1'b0;
        end else if (stall_i) begin
            written_i_q <= 1'b1;
            written_r_q <= 1'b1;
        end else begin
            valid_i_q    <= EX_MEM_valid_i;
            valid_r_q    <= EX_MEM_valid_r;
            regwrite_i_q <= EX_MEM_RegWrite_i;
            regwrite_r_q <= EX_MEM_RegWrite_r;
            written_i_q  <= 1'b0;
            written_r_q  <= 1'b0;
            collide_q    <= collide_in;
            dest_i_q     <= EX_MEM_write_register_i[4:0];
            dest_r_q     <= EX_MEM_write_register_r[4:0];
            data_i_q     <= EX_MEM_MemtoReg_i ? mem_rdata_i : alu_result_i;
            data_r_q     <= EX_MEM_MemtoReg_r ? mem_rdata_r : alu_result_r;
            retire_q     <= retire_q + {30'd0, retire_inc};
            if (collide_in && (coll_q != {CNT_W{1'b1}})) begin
                coll_q <= coll_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Lane r is younger, so on a shared destination it keeps the write and lane i drops it.
    assign MEM_WB_RegWrite_r = valid_r_q & regwrite_r_q & ~written_r_q & (dest_r_q != 5'd0);
    assign MEM_WB_RegWrite_i = valid_i_q & regwrite_i_q & ~written_i_q & (dest_i_q != 5'd0) & ~collide_q;

    assign MEM_WB_write_register_i = {{(ADDR_W-5){1'b0}}, dest_i_q};
    assign MEM_WB_write_register_r = {{(ADDR_W-5){1'b0}}, dest_r_q};
    assign write_data_i            = data_i_q;
    assign write_data_r            = data_r_q;
    assign retire_count            = retire_q;
    assign collision_count         = coll_q;

endmodule

// File: tb/tb_mem_wb_dual_writeback.sv
// Self-checking bench for mem_wb_dual_writeback: directed vector table, stall/reset
// sequences, collision-counter saturation and randomized traffic against a reference model.
module tb_mem_wb_dual_writeback;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              btnc_i, stall_i, flush_i;
    logic              EX_MEM_valid_i, EX_MEM_RegWrite_i, EX_MEM_MemtoReg_i;
    logic [ADDR_W-1:0] EX_MEM_write_register_i;
    logic [DATA_W-1:0] alu_result_i, mem_rdata_i;
    logic              EX_MEM_valid_r, EX_MEM_RegWrite_r, EX_MEM_MemtoReg_r;
    logic [ADDR_W-1:0] EX_MEM_write_register_r;
    logic [DATA_W-1:0] alu_result_r, mem_rdata_r;
    logic              MEM_WB_RegWrite_i, MEM_WB_RegWrite_r;
    logic [ADDR_W-1:0] MEM_WB_write_register_i, MEM_WB_write_register_r;
    logic [DATA_W-1:0] write_data_i, write_data_r;
    logic [31:0]       retire_count;
    logic [CNT_W-1:0]  collision_count;

    mem_wb_dual_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk                     (clk),
        .btnc_i                  (btnc_i),
        .stall_i                 (stall_i),
        .flush_i                 (flush_i),
        .EX_MEM_valid_i          (EX_MEM_valid_i),
        .EX_MEM_RegWrite_i       (EX_MEM_RegWrite_i),
        .EX_MEM_MemtoReg_i       (EX_MEM_MemtoReg_i),
        .EX_MEM_write_register_i (EX_MEM_write_register_i),
        .alu_result_i            (alu_result_i),
        .mem_rdata_i             (mem_rdata_i),
        .EX_MEM_valid_r          (EX_MEM_valid_r),
        .EX_MEM_RegWrite_r       (EX_MEM_RegWrite_r),
        .EX_MEM_MemtoReg_r       (EX_MEM_MemtoReg_r),
        .EX_MEM_write_register_r (EX_MEM_write_register_r),
        .alu_result_r            (alu_result_r),
        .mem_rdata_r             (mem_rdata_r),
        .MEM_WB_RegWrite_i       (MEM_WB_RegWrite_i),
        .MEM_WB_write_register_i (MEM_WB_write_register_i),
        .write_data_i            (write_data_i),
        .MEM_WB_RegWrite_r       (MEM_WB_RegWrite_r),
        .MEM_WB_write_register_r (MEM_WB_write_register_r),
        .write_data_r            (write_data_r),
        .retire_count            (retire_count),
        .collision_count         (collision_count)
    );

    typedef struct packed {
        logic        v;
        logic        rw;
        logic        mtr;
        logic [31:0] dest;
        logic [31:0] alu;
        logic [31:0] mem;
    } lane_t;

    typedef struct packed {
        logic        rwi;
        logic [31:0] regi;
        logic [31:0] di;
        logic        rwr;
        logic [31:0] regr;
        logic [31:0] dr;
        logic [31:0] ret;
        logic [15:0] coll;
    } obs_t;

    typedef struct {
        logic  stall;
        logic  flush;
        lane_t li;
        lane_t lr;
        obs_t  exp;
    } vec_t;

    int nTests = 0;
    int nFail  = 0;

    // Reference model: the entry currently presented, whether this is its first cycle, counters.
    logic        mvi, mvr, mrwi, mrwr, mfresh;
    logic [4:0]  mdi, mdr;
    logic [31:0] mdati, mdatr, mret;
    logic [15:0] mcoll;

    function automatic lane_t mkLane(logic v, logic rw, logic mtr, logic [31:0] dest,
                                     logic [31:0] alu, logic [31:0] mem);
        lane_t l;
        l.v = v; l.rw = rw; l.mtr = mtr; l.dest = dest; l.alu = alu; l.mem = mem;
        return l;
    endfunction

    function automatic obs_t mkObs(logic rwi, logic [31:0] regi, logic [31:0] di, logic rwr,
                                   logic [31:0] regr, logic [31:0] dr, logic [31:0] ret,
                                   logic [15:0] coll);
        obs_t o;
        o.rwi = rwi; o.regi = regi; o.di = di; o.rwr = rwr;
        o.regr = regr; o.dr = dr; o.ret = ret; o.coll = coll;
        return o;
    endfunction

    function automatic obs_t sampleDut();
        return mkObs(MEM_WB_RegWrite_i, MEM_WB_write_register_i, write_data_i,
                     MEM_WB_RegWrite_r, MEM_WB_write_register_r, write_data_r,
                     retire_count, collision_count);
    endfunction

    function automatic void modelReset();
        mvi = 0; mvr = 0; mrwi = 0; mrwr = 0; mfresh = 0;
        mdi = 0; mdr = 0; mdati = 0; mdatr = 0; mret = 0; mcoll = 0;
    endfunction

    function automatic void modelStep(logic rst, logic stall, logic flush, lane_t a, lane_t b);
        logic wi, wr;
        if (rst) begin
            modelReset();
        end else if (flush) begin
            mvi = 0; mvr = 0; mfresh = 0;
        end else if (stall) begin
            mfresh = 0;
        end else begin
            mvi = a.v; mvr = b.v; mrwi = a.rw; mrwr = b.rw;
            mdi = a.dest[4:0]; mdr = b.dest[4:0];
            mdati = a.mtr ? a.mem : a.alu;
            mdatr = b.mtr ? b.mem : b.alu;
            mfresh = 1;
            mret = mret + 32'(a.v) + 32'(b.v);
            wi = a.v && a.rw && (mdi != 0);
            wr = b.v && b.rw && (mdr != 0);
            if (wi && wr && (mdi == mdr) && (mcoll != 16'hFFFF)) mcoll = mcoll + 16'd1;
        end
    endfunction

    function automatic obs_t modelExpect();
        logic enr, eni;
        enr = mfresh && mvr && mrwr && (mdr != 0);
        eni = mfresh && mvi && mrwi && (mdi != 0) && !(enr && (mdi == mdr));
        return mkObs(eni, {27'd0, mdi}, mdati, enr, {27'd0, mdr}, mdatr, mret, mcoll);
    endfunction

    task automatic driveLanes(input logic stall, input logic flush, input lane_t a, input lane_t b);
        stall_i = stall; flush_i = flush;
        EX_MEM_valid_i = a.v; EX_MEM_RegWrite_i = a.rw; EX_MEM_MemtoReg_i = a.mtr;
        EX_MEM_write_register_i = a.dest; alu_result_i = a.alu; mem_rdata_i = a.mem;
        EX_MEM_valid_r = b.v; EX_MEM_RegWrite_r = b.rw; EX_MEM_MemtoReg_r = b.mtr;
        EX_MEM_write_register_r = b.dest; alu_result_r = b.alu; mem_rdata_r = b.mem;
    endtask

    // Drive on the falling edge, let the rising edge act, then sample just after it.
    task automatic applyStimulus(input logic rst, input logic stall, input logic flush,
                                 input lane_t a, input lane_t b);
        @(negedge clk);
        btnc_i = rst;
        driveLanes(stall, flush, a, b);
        @(posedge clk);
        modelStep(rst, stall, flush, a, b);
        #1;
    endtask

    task automatic checkOutput(input string name, input obs_t exp);
        obs_t act;
        act = sampleDut();
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got rwi=%0b regi=%h di=%h rwr=%0b regr=%h dr=%h ret=%0d coll=%0d, want rwi=%0b regi=%h di=%h rwr=%0b regr=%h dr=%h ret=%0d coll=%0d",
                     name, act.rwi, act.regi, act.di, act.rwr, act.regr, act.dr, act.ret, act.coll,
                     exp.rwi, exp.regi, exp.di, exp.rwr, exp.regr, exp.dr, exp.ret, exp.coll);
        end
    endtask

    vec_t  vecs[9];
    lane_t idle, la, lb;
    obs_t  zeroObs;

    initial begin
        idle    = mkLane(0, 0, 0, 0, 0, 0);
        zeroObs = mkObs(0, 0, 0, 0, 0, 0, 0, 0);

        vecs[0] = '{0, 0, mkLane(1,1,0,32'd3,32'h11,32'h99), mkLane(1,1,1,32'd5,32'h77,32'h22),
                    mkObs(1,32'd3,32'h11,1,32'd5,32'h22,32'd2,16'd0)};
        vecs[1] = '{0, 0, mkLane(1,1,0,32'd7,32'hA,32'h0), mkLane(1,1,0,32'd7,32'hB,32'h0),
                    mkObs(0,32'd7,32'hA,1,32'd7,32'hB,32'd4,16'd1)};
        vecs[2] = '{0, 0, mkLane(1,1,0,32'd0,32'h33,32'h0), mkLane(0,1,0,32'd9,32'h44,32'h0),
                    mkObs(0,32'd0,32'h33,0,32'd9,32'h44,32'd5,16'd1)};
        vecs[3] = '{0, 0, mkLane(1,1,1,32'h25,32'h1,32'h55), mkLane(1,0,0,32'd6,32'h66,32'h0),
                    mkObs(1,32'd5,32'h55,0,32'd6,32'h66,32'd7,16'd1)};
        vecs[4] = '{1, 1, mkLane(1,1,0,32'd8,32'hEE,32'h0), mkLane(1,1,0,32'd9,32'hFF,32'h0),
                    mkObs(0,32'd5,32'h55,0,32'd6,32'h66,32'd7,16'd1)};
        vecs[5] = '{0, 1, mkLane(1,1,0,32'd10,32'hEE,32'h0), mkLane(1,1,0,32'd10,32'hFF,32'h0),
                    mkObs(0,32'd5,32'h55,0,32'd6,32'h66,32'd7,16'd1)};
        vecs[6] = '{0, 0, mkLane(1,1,0,32'h3F,32'h12,32'h0), mkLane(1,1,1,32'hFFFF_FF1F,32'h0,32'h34),
                    mkObs(0,32'd31,32'h12,1,32'd31,32'h34,32'd9,16'd2)};
        vecs[7] = '{0, 0, mkLane(1,1,0,32'd0,32'h1,32'h0), mkLane(1,1,0,32'd0,32'h2,32'h0),
                    mkObs(0,32'd0,32'h1,0,32'd0,32'h2,32'd11,16'd2)};
        vecs[8] = '{0, 0, mkLane(1,1,0,32'd12,32'h3,32'h0), mkLane(1,0,0,32'd12,32'h4,32'h0),
                    mkObs(1,32'd12,32'h3,0,32'd12,32'h4,32'd13,16'd2)};

        btnc_i = 1'b1;
        driveLanes(0, 0, idle, idle);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", zeroObs);

        for (int k = 0; k < 9; k++) begin
            applyStimulus(0, vecs[k].stall, vecs[k].flush, vecs[k].li, vecs[k].lr);
            checkOutput($sformatf("vec%0d", k), vecs[k].exp);
        end

        // Held entry writes once and does not recount.
        la = mkLane(1,1,0,32'd9,32'h99,32'h0);
        applyStimulus(0, 0, 0, mkLane(1,1,0,32'd4,32'h5,32'h0), idle);
        checkOutput("stall_first", mkObs(1,32'd4,32'h5,0,32'd0,32'd0,32'd14,16'd2));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, 0, la, la);
            checkOutput($sformatf("stall_hold%0d", k), mkObs(0,32'd4,32'h5,0,32'd0,32'd0,32'd14,16'd2));
        end

        // Colliding entry held: counted once.
        applyStimulus(0, 0, 0, mkLane(1,1,0,32'd2,32'h21,32'h0), mkLane(1,1,0,32'd2,32'h22,32'h0));
        checkOutput("coll_first", mkObs(0,32'd2,32'h21,1,32'd2,32'h22,32'd16,16'd3));
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 1, 0, la, la);
            checkOutput($sformatf("coll_hold%0d", k), mkObs(0,32'd2,32'h21,0,32'd2,32'h22,32'd16,16'd3));
        end

        // Half-cycle reset mid-stall clears before the next edge; next capture is normal.
        @(negedge clk);
        btnc_i = 1'b1;
        #1;
        checkOutput("async_reset", zeroObs);
        #2;
        btnc_i = 1'b0;
        modelReset();
        la = mkLane(1,1,0,32'd4,32'h5,32'h0);
        lb = mkLane(1,1,0,32'd6,32'h7,32'h0);
        driveLanes(0, 0, la, lb);
        @(posedge clk);
        modelStep(0, 0, 0, la, lb);
        #1;
        checkOutput("post_reset_capture", mkObs(1,32'd4,32'h5,1,32'd6,32'h7,32'd2,16'd0));

        // Randomized traffic against the reference model.
        for (int k = 0; k < 800; k++) begin
            logic rst, st, fl;
            rst = ($urandom_range(0, 99) == 0);
            st  = ($urandom_range(0, 99) < 20);
            fl  = ($urandom_range(0, 99) < 10);
            la = mkLane(1'($urandom), 1'($urandom), 1'($urandom),
                        (($urandom_range(0,1) == 1) ? ($urandom & 32'hFFFF_FFE0) : 32'd0) | 32'($urandom_range(0, 7)),
                        $urandom, $urandom);
            lb = mkLane(1'($urandom), 1'($urandom), 1'($urandom),
                        (($urandom_range(0,1) == 1) ? ($urandom & 32'hFFFF_FFE0) : 32'd0) | 32'($urandom_range(0, 7)),
                        $urandom, $urandom);
            applyStimulus(rst, st, fl, la, lb);
            checkOutput($sformatf("rand%0d", k), modelExpect());
            if (nFail > 20) break;
        end

        // Collision counter saturates at all-ones.
        applyStimulus(1, 0, 0, idle, idle);
        checkOutput("sat_reset", zeroObs);
        la = mkLane(1,1,0,32'd17,32'h1,32'h0);
        lb = mkLane(1,1,0,32'd17,32'h2,32'h0);
        for (int k = 0; k < 65540; k++) begin
            applyStimulus(0, 0, 0, la, lb);
        end
        checkOutput("coll_saturate", mkObs(0,32'd17,32'h1,1,32'd17,32'h2,32'd131080,16'hFFFF));

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
